// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh terminal transmit path.
//  - pkt_t: packet layout {nxt_jmp, row, col, mode, payload}, MSB first
//  - field offsets measured down from the packet MSB
//  - is_terminal_addr(): true when (row, col) names a border terminal
package mesh_pkg;

  localparam int unsigned PCKG_SZ      = 40;
  localparam int unsigned NXT_W        = 8;
  localparam int unsigned ROW_W        = 4;
  localparam int unsigned COL_W        = 4;
  localparam int unsigned HDR_W        = NXT_W + ROW_W + COL_W + 1;
  localparam int unsigned PAYLOAD_W    = PCKG_SZ - HDR_W;

  // Distance of each field's top bit below the packet MSB.
  localparam int unsigned NXT_MSB_OFS  = 0;
  localparam int unsigned ROW_MSB_OFS  = 8;
  localparam int unsigned COL_MSB_OFS  = 12;
  localparam int unsigned MODE_OFS     = 16;

  typedef struct packed {
    logic [NXT_W-1:0]     nxt_jmp;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     col;
    logic                 mode;
    logic [PAYLOAD_W-1:0] payload;
  } pkt_t;

  // Border terminals sit on rows 0/ROWS+1 (columns 1..COLUMS) or on
  // columns 0/COLUMS+1 (rows 1..ROWS); corners are not terminals.
  function automatic logic is_terminal_addr(input logic [ROW_W-1:0] row,
                                            input logic [COL_W-1:0] col,
                                            input int unsigned      rows,
                                            input int unsigned      colums);
    int unsigned r;
    int unsigned c;
    r = {28'd0, row};
    c = {28'd0, col};
    return ((r == 0 || r == rows + 1) && c >= 1 && c <= colums) ||
           ((c == 0 || c == colums + 1) && r >= 1 && r <= rows);
  endfunction

endpackage

// File: rtl/mesh_term_tx_queue_if.sv
// Agent/mesh-facing bundle of mesh_term_tx_queue.
//  push, push_data      : packet offered by the terminal agent
//  full                 : queue holds fifo_depth entries
//  popin                : mesh consumes the head entry
//  data_out_i_in        : head packet (0 while empty)
//  pndng_i_in           : queue not empty
//  drop_cnt             : saturating count of bad-header packets
//  overflow, underflow  : sticky error flags
// slave = queue side, master = agent/mesh side.
interface mesh_term_tx_queue_if #(
  parameter int unsigned pckg_sz = 40
);
  logic               push;
  logic [pckg_sz-1:0] push_data;
  logic               full;
  logic               popin;
  logic [pckg_sz-1:0] data_out_i_in;
  logic               pndng_i_in;
  logic [15:0]        drop_cnt;
  logic               overflow;
  logic               underflow;

  modport slave (
    input  push, push_data, popin,
    output full, data_out_i_in, pndng_i_in, drop_cnt, overflow, underflow
  );

  modport master (
    output push, push_data, popin,
    input  full, data_out_i_in, pndng_i_in, drop_cnt, overflow, underflow
  );
endinterface

// File: rtl/mesh_fwft_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on o_rd_data
// whenever o_empty is low. Depth need not be a power of two.
//  clk, reset (sync, active-high)
//  i_wr_en, i_wr_data : write (ignored while full)
//  i_rd_en            : advance head (ignored while empty)
//  o_rd_data          : head entry, 0 while empty
//  o_full, o_empty    : decoded from the registered count
module mesh_fwft_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_wr;
  logic w_rd;

  assign w_wr = i_wr_en & ~o_full;
  assign w_rd = i_rd_en & ~o_empty;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_rd) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; stale contents are hidden by the count.
  always_ff @(posedge clk) begin
    if (!reset && w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/mesh_term_tx_queue.sv
// Terminal-side transmit queue feeding one mesh router input.
// Checks the destination header of each agent packet, stores valid packets
// (with nxt_jmp cleared) in a FWFT FIFO, and presents the head to the mesh.
//  clk, reset : single clock, synchronous active-high reset
//  bus        : mesh_term_tx_queue_if.slave (push/push_data/full,
//               popin/data_out_i_in/pndng_i_in, drop_cnt, overflow, underflow)
module mesh_term_tx_queue
  import mesh_pkg::*;
#(
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMS     = 4,
  parameter int unsigned MY_ROW     = 0,
  parameter int unsigned MY_COL     = 1
) (
  input logic                  clk,
  input logic                  reset,
  mesh_term_tx_queue_if.slave  bus
);

  localparam int unsigned ROW_HI  = pckg_sz - 1 - ROW_MSB_OFS;
  localparam int unsigned COL_HI  = pckg_sz - 1 - COL_MSB_OFS;
  localparam int unsigned MODE_B  = pckg_sz - 1 - MODE_OFS;
  localparam logic [pckg_sz-1:0] NXT_CLR = {{NXT_W{1'b0}}, {(pckg_sz-NXT_W){1'b1}}};

  logic [ROW_W-1:0]   w_row;
  logic [COL_W-1:0]   w_col;
  logic               w_mode;
  logic               w_hdr_ok;
  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_enq;
  logic               w_drop;
  logic [pckg_sz-1:0] w_store;

  logic [15:0]        r_drop_cnt;
  logic               r_overflow;
  logic               r_underflow;

  assign w_row  = bus.push_data[ROW_HI -: ROW_W];
  assign w_col  = bus.push_data[COL_HI -: COL_W];
  assign w_mode = bus.push_data[MODE_B];

  // Mode is a single bit, so its range check always holds.
  assign w_hdr_ok = is_terminal_addr(w_row, w_col, ROWS, COLUMS) &&
                    !((w_row == ROW_W'(MY_ROW)) && (w_col == COL_W'(MY_COL))) &&
                    ((w_mode == 1'b0) || (w_mode == 1'b1));

  // full is the registered state: a push while full is rejected even if a
  // pop frees a slot in the same cycle.
  assign w_accept = bus.push & ~w_full;
  assign w_enq    = w_accept &  w_hdr_ok;
  assign w_drop   = w_accept & ~w_hdr_ok;
  assign w_store  = bus.push_data & NXT_CLR;

  mesh_fwft_fifo #(
    .WIDTH (pckg_sz),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_enq),
    .i_wr_data (w_store),
    .i_rd_en   (bus.popin),
    .o_rd_data (bus.data_out_i_in),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (bus.push && w_full)         r_overflow  <= 1'b1;
      if (bus.popin && w_empty)       r_underflow <= 1'b1;
    end
  end

  assign bus.full       = w_full;
  assign bus.pndng_i_in = ~w_empty;
  assign bus.drop_cnt   = r_drop_cnt;
  assign bus.overflow   = r_overflow;
  assign bus.underflow  = r_underflow;

endmodule

// File: tb/tb_mesh_term_tx_queue.sv
module tb_mesh_term_tx_queue;
  import mesh_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mesh_term_tx_queue_if #(.pckg_sz(40)) bus ();

  mesh_term_tx_queue #(
    .pckg_sz    (40),
    .fifo_depth (4),
    .ROWS       (4),
    .COLUMS     (4),
    .MY_ROW     (0),
    .MY_COL     (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [3:0] row, input logic [3:0] col,
                              input logic [22:0] pl, input logic [7:0] nxt);
    pkt_t p;
    p.nxt_jmp = nxt;
    p.row     = row;
    p.col     = col;
    p.mode    = pl[0];
    p.payload = pl;
    return p;
  endfunction

  function automatic logic [63:0] xp(input pkt_t p);
    pkt_t q;
    q = p;
    q.nxt_jmp = 8'h00;
    return {24'd0, q};
  endfunction

  pkt_t a, q[5], s[5], t;

  initial begin
    reset = 1'b1;
    bus.push = 1'b0;
    bus.push_data = '0;
    bus.popin = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("init_pndng", {63'd0, bus.pndng_i_in}, 64'd0);
    chk("init_data", {24'd0, bus.data_out_i_in}, 64'd0);

    // 1: reset with one entry queued, popin in the reset cycle ignored
    a = mk(4'd0, 4'd3, 23'h00_0777, 8'h11);
    bus.push = 1'b1; bus.push_data = a;
    tick();
    bus.push = 1'b0;
    chk("t1_pre_pndng", {63'd0, bus.pndng_i_in}, 64'd1);
    reset = 1'b1; bus.popin = 1'b1;
    tick();
    chk("t1_rst_pndng", {63'd0, bus.pndng_i_in}, 64'd0);
    chk("t1_rst_full", {63'd0, bus.full}, 64'd0);
    chk("t1_rst_drop", {48'd0, bus.drop_cnt}, 64'd0);
    bus.popin = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("t1_post_pndng", {63'd0, bus.pndng_i_in}, 64'd0);
    chk("t1_post_data", {24'd0, bus.data_out_i_in}, 64'd0);
    chk("t1_post_uflow", {63'd0, bus.underflow}, 64'd0);

    // 2: single packet, 1-cycle latency, nxt_jmp cleared
    a = mk(4'd0, 4'd2, 23'h00_1234, 8'h5A);
    bus.push = 1'b1; bus.push_data = a;
    tick();
    bus.push = 1'b0;
    chk("t2_pndng", {63'd0, bus.pndng_i_in}, 64'd1);
    chk("t2_data", {24'd0, bus.data_out_i_in}, xp(a));
    bus.popin = 1'b1;
    tick();
    bus.popin = 1'b0;
    chk("t2_pop_pndng", {63'd0, bus.pndng_i_in}, 64'd0);

    // 3: fill, overflow, drain in order
    q[0] = mk(4'd0, 4'd2, 23'h00_0A01, 8'hFF);
    q[1] = mk(4'd5, 4'd1, 23'h00_0B02, 8'h01);
    q[2] = mk(4'd1, 4'd0, 23'h00_0C03, 8'h80);
    q[3] = mk(4'd3, 4'd5, 23'h7F_FFFF, 8'h3C);
    q[4] = mk(4'd0, 4'd4, 23'h00_0E05, 8'h22);
    bus.push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.push_data = q[i];
      tick();
    end
    chk("t3_full", {63'd0, bus.full}, 64'd1);
    chk("t3_oflow_pre", {63'd0, bus.overflow}, 64'd0);
    bus.push_data = q[4];
    tick();
    bus.push = 1'b0;
    chk("t3_oflow", {63'd0, bus.overflow}, 64'd1);
    chk("t3_drop", {48'd0, bus.drop_cnt}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_pop%0d", i), {24'd0, bus.data_out_i_in}, xp(q[i]));
      bus.popin = 1'b1;
      tick();
      bus.popin = 1'b0;
    end
    chk("t3_empty", {63'd0, bus.pndng_i_in}, 64'd0);

    // 4: interior destination and own address are dropped
    bus.push = 1'b1;
    bus.push_data = mk(4'd2, 4'd2, 23'h00_0001, 8'h00);
    tick();
    bus.push_data = mk(4'd0, 4'd1, 23'h00_0002, 8'h00);
    tick();
    bus.push = 1'b0;
    chk("t4_drop", {48'd0, bus.drop_cnt}, 64'd2);
    chk("t4_pndng", {63'd0, bus.pndng_i_in}, 64'd0);

    // 5a: two entries, push + pop together keeps two, order preserved
    s[0] = mk(4'd0, 4'd2, 23'h00_5100, 8'h09);
    s[1] = mk(4'd5, 4'd4, 23'h00_5101, 8'h09);
    s[2] = mk(4'd4, 4'd0, 23'h00_5102, 8'h09);
    bus.push = 1'b1;
    bus.push_data = s[0]; tick();
    bus.push_data = s[1]; tick();
    bus.push_data = s[2]; bus.popin = 1'b1;
    tick();
    bus.push = 1'b0; bus.popin = 1'b0;
    chk("t5a_head", {24'd0, bus.data_out_i_in}, xp(s[1]));
    bus.popin = 1'b1; tick();
    chk("t5a_second", {24'd0, bus.data_out_i_in}, xp(s[2]));
    tick();
    bus.popin = 1'b0;
    chk("t5a_empty", {63'd0, bus.pndng_i_in}, 64'd0);

    // 5b: full, push + pop together: push rejected, three remain
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5b_oflow_clr", {63'd0, bus.overflow}, 64'd0);
    s[0] = mk(4'd0, 4'd2, 23'h00_6200, 8'h44);
    s[1] = mk(4'd0, 4'd3, 23'h00_6201, 8'h44);
    s[2] = mk(4'd0, 4'd4, 23'h00_6202, 8'h44);
    s[3] = mk(4'd5, 4'd2, 23'h00_6203, 8'h44);
    s[4] = mk(4'd5, 4'd3, 23'h00_6204, 8'h44);
    bus.push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.push_data = s[i];
      tick();
    end
    bus.push_data = s[4]; bus.popin = 1'b1;
    tick();
    bus.push = 1'b0;
    chk("t5b_oflow", {63'd0, bus.overflow}, 64'd1);
    chk("t5b_full", {63'd0, bus.full}, 64'd0);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("t5b_pop%0d", i), {24'd0, bus.data_out_i_in}, xp(s[i]));
      tick();
    end
    bus.popin = 1'b0;
    chk("t5b_empty", {63'd0, bus.pndng_i_in}, 64'd0);

    // 6: underflow, then normal operation continues
    reset = 1'b1; tick(); reset = 1'b0;
    bus.popin = 1'b1; tick(); bus.popin = 1'b0;
    chk("t6_uflow", {63'd0, bus.underflow}, 64'd1);
    chk("t6_pndng", {63'd0, bus.pndng_i_in}, 64'd0);
    t = mk(4'd5, 4'd3, 23'h2A_AAAA, 8'h77);
    bus.push = 1'b1; bus.push_data = t;
    tick();
    bus.push = 1'b0;
    chk("t6_data", {24'd0, bus.data_out_i_in}, xp(t));
    bus.popin = 1'b1; tick(); bus.popin = 1'b0;
    chk("t6_empty", {63'd0, bus.pndng_i_in}, 64'd0);
    chk("t6_uflow_sticky", {63'd0, bus.underflow}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
